// File: rtl/csa_resolve_serial.sv
// Chunk-serial carry-propagate adder that resolves a carry-save pair (C, S) into sum + carry_out.
// Optional macro CSA_RESOLVE_EARLY_EXIT_EN finishes early once the carry dies and all upper operand chunks are zero.
module csa_resolve_serial #(
    parameter int BIT_LEN   = 32,
    parameter int CHUNK_LEN = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_LEN-1:0] C,
    input  logic [BIT_LEN-1:0] S,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BIT_LEN-1:0] sum,
    output logic               carry_out
);
    localparam int NUM_CHUNKS = (BIT_LEN + CHUNK_LEN - 1) / CHUNK_LEN;
    localparam int PAD_LEN    = NUM_CHUNKS * CHUNK_LEN;
    localparam int LAST_LEN   = BIT_LEN - (NUM_CHUNKS - 1) * CHUNK_LEN;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t             state_q, state_d;
    logic [PAD_LEN-1:0] c_q, s_q;
    logic [BIT_LEN-1:0] sum_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q;
    logic               carry_out_q;
    logic               primed_q;
    int                 base;
    logic [CHUNK_LEN:0] chunk_sum;
    logic               last_chunk;
    logic               early_exit;
    logic               finish;

    // The operands are zero-extended to whole chunks, so the carry out of bit BIT_LEN-1
    // in a partial last chunk lands at chunk_sum[LAST_LEN].
    always_comb begin
        base       = int'(idx_q) * CHUNK_LEN;
        chunk_sum  = {1'b0, c_q[base +: CHUNK_LEN]} + {1'b0, s_q[base +: CHUNK_LEN]}
                   + {{CHUNK_LEN{1'b0}}, carry_q};
        last_chunk = (idx_q == LAST_IDX);
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
        early_exit = !chunk_sum[CHUNK_LEN] && (((c_q | s_q) >> (base + CHUNK_LEN)) == '0);
`else
        early_exit = 1'b0;
`endif
        finish     = primed_q && (last_chunk || early_exit);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = ADD;
            ADD:     if (finish) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first ADD cycle is the load cycle; chunks are added from the second one on.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            c_q         <= '0;
            s_q         <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            primed_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        c_q      <= PAD_LEN'(C);
                        s_q      <= PAD_LEN'(S);
                        sum_q    <= '0;
                        carry_q  <= 1'b0;
                        idx_q    <= '0;
                        primed_q <= 1'b0;
                    end
                end
                ADD: begin
                    if (!primed_q) begin
                        primed_q <= 1'b1;
                    end else begin
                        sum_q   <= sum_q | BIT_LEN'(PAD_LEN'(chunk_sum[CHUNK_LEN-1:0]) << base);
                        carry_q <= chunk_sum[CHUNK_LEN];
                        if (finish)
                            carry_out_q <= last_chunk ? chunk_sum[LAST_LEN] : 1'b0;
                        else
                            idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry_out = carry_out_q;
endmodule

// File: tb/tb_csa_resolve_serial.sv
// Directed bench for csa_resolve_serial: a 16/4 instance for the main scenarios and a 10/4 instance
// for the partial-chunk and streaming scenarios. Latency expectations follow CSA_RESOLVE_EARLY_EXIT_EN.
module tb_csa_resolve_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_carry_out;
    logic [15:0] a_c, a_s, a_sum;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_carry_out;
    logic [9:0]  b_c, b_s, b_sum;

    int checks = 0;
    int errors = 0;
    logic [10:0] golden[$];

    csa_resolve_serial #(.BIT_LEN(16), .CHUNK_LEN(4)) dut_a (
        .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .C(a_c), .S(a_s), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .sum(a_sum), .carry_out(a_carry_out)
    );

    csa_resolve_serial #(.BIT_LEN(10), .CHUNK_LEN(4)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .C(b_c), .S(b_s), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .sum(b_sum), .carry_out(b_carry_out)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Presents a pair to dut_a, waits for acceptance, and returns the edges until out_valid.
    task automatic applyStimulus(input logic [15:0] c, input logic [15:0] s, output int lat);
        int guard = 0;
        a_c = c;
        a_s = s;
        a_in_valid = 1'b1;
        while (!a_in_ready && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput("a_in_ready_before_accept", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        a_c = 16'hDEAD;
        a_s = 16'hBEEF;
        lat = 0;
        while (!a_out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic runOp(input string tag, input logic [15:0] c, input logic [15:0] s,
                         input logic [15:0] exp_sum, input logic exp_cy, input int exp_lat);
        int lat;
        applyStimulus(c, s, lat);
        checkOutput({tag, "_latency"}, lat, exp_lat);
        checkOutput({tag, "_sum"}, a_sum, exp_sum);
        checkOutput({tag, "_carry_out"}, a_carry_out, exp_cy);
    endtask

    initial begin
        int lat;
        bit seen;
        reset = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_c = '0; a_s = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_c = '0; b_s = '0;
        tick();
        tick();
        checkOutput("reset_a_in_ready", a_in_ready, 1);
        checkOutput("reset_a_out_valid", a_out_valid, 0);
        checkOutput("reset_a_sum", a_sum, 0);
        checkOutput("reset_a_carry_out", a_carry_out, 0);
        checkOutput("reset_b_in_ready", b_in_ready, 1);
        checkOutput("reset_b_out_valid", b_out_valid, 0);
        reset = 1'b0;
        tick();

`ifdef CSA_RESOLVE_EARLY_EXIT_EN
        runOp("basic", 16'h00FF, 16'h0001, 16'h0100, 1'b0, 4);
`else
        runOp("basic", 16'h00FF, 16'h0001, 16'h0100, 1'b0, 5);
`endif
        tick();
        runOp("ripple_ffff", 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 5);
        tick();
        runOp("ripple_8000", 16'h8000, 16'h8000, 16'h0000, 1'b1, 5);
        tick();
`ifdef CSA_RESOLVE_EARLY_EXIT_EN
        runOp("early_3_4", 16'h0003, 16'h0004, 16'h0007, 1'b0, 2);
        tick();
        runOp("early_f_1", 16'h000F, 16'h0001, 16'h0010, 1'b0, 3);
`else
        runOp("early_3_4", 16'h0003, 16'h0004, 16'h0007, 1'b0, 5);
        tick();
        runOp("early_f_1", 16'h000F, 16'h0001, 16'h0010, 1'b0, 5);
`endif
        tick();

        // Backpressure: result must stay parked while out_ready is low.
        a_out_ready = 1'b0;
        runOp("bp", 16'h1234, 16'h4321, 16'h5555, 1'b0, 5);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_out_valid", a_out_valid, 1);
            checkOutput("bp_sum", a_sum, 16'h5555);
            checkOutput("bp_in_ready", a_in_ready, 0);
        end
        a_out_ready = 1'b1;
        tick();
        checkOutput("bp_release_out_valid", a_out_valid, 0);
        checkOutput("bp_release_in_ready", a_in_ready, 1);

        // Reset two cycles after acceptance discards the computation.
        a_c = 16'hFFFF;
        a_s = 16'h0001;
        a_in_valid = 1'b1;
        checkOutput("rst_in_ready_before_accept", a_in_ready, 1);
        tick();
        a_in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rst_in_ready", a_in_ready, 1);
        checkOutput("rst_out_valid", a_out_valid, 0);
        checkOutput("rst_sum", a_sum, 0);
        checkOutput("rst_carry_out", a_carry_out, 0);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (a_out_valid) seen = 1'b1;
        end
        checkOutput("rst_no_out_valid_pulse", seen, 0);

        // Partial last chunk on the 10-bit instance.
        b_c = 10'h3FF;
        b_s = 10'h001;
        b_in_valid = 1'b1;
        checkOutput("part_in_ready", b_in_ready, 1);
        tick();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 50) begin
            tick();
            lat++;
        end
        checkOutput("part_latency", lat, 4);
        checkOutput("part_sum", b_sum, 10'h000);
        checkOutput("part_carry_out", b_carry_out, 1);
        tick();

        // Streaming: in_valid held high, every accepted pair must come back exactly once.
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    int guard = 0;
                    b_c = 10'($urandom_range(0, 1023));
                    b_s = 10'($urandom_range(0, 1023));
                    b_in_valid = 1'b1;
                    while (!b_in_ready && guard < 100) begin
                        tick();
                        guard++;
                    end
                    checkOutput("stream_in_ready", b_in_ready, 1);
                    golden.push_back({1'b0, b_c} + {1'b0, b_s});
                    tick();
                end
                b_in_valid = 1'b0;
            end
            begin
                int got = 0;
                int cyc = 0;
                logic [10:0] exp_val;
                while (got < 20 && cyc < 3000) begin
                    @(negedge clk);
                    cyc++;
                    if (b_out_valid && b_out_ready) begin
                        if (golden.size() == 0) begin
                            checkOutput("stream_unexpected_result", {b_carry_out, b_sum}, 11'h7FF);
                            exp_val = 11'h7FF;
                        end else begin
                            exp_val = golden.pop_front();
                            checkOutput("stream_result", {b_carry_out, b_sum}, exp_val);
                        end
                        got++;
                    end
                end
                checkOutput("stream_count", got, 20);
            end
        join
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (b_out_valid) seen = 1'b1;
        end
        checkOutput("stream_no_extra_result", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
